// File: rtl/layer_vector_streamer_pkg.sv
// Shared types and defaults for the layer input streamer.
// Element type is signed; bank select is a single bit that toggles between the ping-pong banks.
package layer_stream_pkg;

    localparam int T_DEFAULT = 16;
    localparam int N_DEFAULT = 8;

    typedef logic signed [T_DEFAULT-1:0] elem_t;
    typedef logic bank_sel_t;

    function automatic bank_sel_t other_bank(input bank_sel_t b);
        return ~b;
    endfunction

endpackage

// File: rtl/layer_vector_streamer_bank.sv
// One N x T register file: single write port, asynchronous read port.
// Out-of-range write addresses are dropped so non-power-of-two N stays safe.
module stream_bank #(
    parameter int T = 16,
    parameter int N = 8,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [T-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [T-1:0]  rdata
);

    logic [T-1:0] regs [N];

    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < N)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/layer_vector_streamer.sv
// Ping-pong frame buffer that replays committed N-element vectors over a valid/ready stream.
// All outputs are derived from registered state only.
module layer_vector_streamer
    import layer_stream_pkg::*;
#(
    parameter int T = T_DEFAULT,
    parameter int N = N_DEFAULT,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [T-1:0]  wr_data,
    input  logic          wr_last,
    output logic          wr_ready,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [T-1:0]  m_data,
    output logic          m_last
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    logic [1:0]    full;
    bank_sel_t     wb;
    bank_sel_t     rb;
    logic [AW-1:0] ri;

    logic          wr_accept;
    logic          commit;
    logic          handshake;
    logic          frame_done;
    logic [T-1:0]  rdata0;
    logic [T-1:0]  rdata1;
    logic [T-1:0]  rd_sel;

    assign wr_accept  = wr_en && !full[wb];
    assign commit     = wr_accept && wr_last;
    assign handshake  = full[rb] && m_ready;
    assign frame_done = handshake && (ri == LAST_IDX);

    stream_bank #(.T(T), .N(N)) u_bank0 (
        .clk   (clk),
        .we    (wr_accept && (wb == 1'b0)),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (ri),
        .rdata (rdata0)
    );

    stream_bank #(.T(T), .N(N)) u_bank1 (
        .clk   (clk),
        .we    (wr_accept && (wb == 1'b1)),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (ri),
        .rdata (rdata1)
    );

    // Commit and final handshake always hit different banks, so both bit updates may land together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            full <= 2'b00;
            wb   <= 1'b0;
            rb   <= 1'b0;
            ri   <= '0;
        end else begin
            if (commit) begin
                full[wb] <= 1'b1;
                wb       <= other_bank(wb);
            end
            if (frame_done) begin
                ri       <= '0;
                full[rb] <= 1'b0;
                rb       <= other_bank(rb);
            end else if (handshake) begin
                ri <= ri + 1'b1;
            end
        end
    end

    assign rd_sel   = rb ? rdata1 : rdata0;
    assign wr_ready = !full[wb];
    assign m_valid  = full[rb];
    assign m_data   = m_valid ? rd_sel : '0;
    assign m_last   = m_valid && (ri == LAST_IDX);

endmodule

// File: tb/tb_layer_vector_streamer.sv
// Self-checking bench for layer_vector_streamer: directed scenarios plus a randomized
// scoreboard run against a frame-queue reference model; a second N=6 instance covers odd sizes.
`timescale 1ns/1ps
module tb_layer_vector_streamer;
    import layer_stream_pkg::*;

    localparam int N  = 8;
    localparam int N6 = 6;
    localparam int RAND_FRAMES = 1000;
    localparam int CYCLE_CAP = 60000;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_last;
    logic        wr_ready;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;

    logic        s6_wr_en;
    logic [2:0]  s6_wr_addr;
    logic [15:0] s6_wr_data;
    logic        s6_wr_last;
    logic        s6_wr_ready;
    logic        s6_m_valid;
    logic        s6_m_ready;
    logic [15:0] s6_m_data;
    logic        s6_m_last;

    int tests;
    int fails;

    layer_vector_streamer #(.T(16), .N(N)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    layer_vector_streamer #(.T(16), .N(N6)) dut6 (
        .clk(clk), .reset(reset),
        .wr_en(s6_wr_en), .wr_addr(s6_wr_addr), .wr_data(s6_wr_data), .wr_last(s6_wr_last),
        .wr_ready(s6_wr_ready), .m_valid(s6_m_valid), .m_ready(s6_m_ready),
        .m_data(s6_m_data), .m_last(s6_m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        wr_en = 0; wr_addr = '0; wr_data = '0; wr_last = 0; m_ready = 0;
        s6_wr_en = 0; s6_wr_addr = '0; s6_wr_data = '0; s6_wr_last = 0; s6_m_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Drive one write for one cycle starting at a falling edge; returns at the next falling edge.
    task automatic write8(input int addr, input int data, input bit last);
        wr_en = 1; wr_addr = 3'(addr); wr_data = 16'(data); wr_last = last;
        @(negedge clk);
        wr_en = 0; wr_last = 0;
    endtask

    task automatic write6(input int addr, input int data, input bit last);
        s6_wr_en = 1; s6_wr_addr = 3'(addr); s6_wr_data = 16'(data); s6_wr_last = last;
        @(negedge clk);
        s6_wr_en = 0; s6_wr_last = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_wr_ready got %b want 1", wr_ready); end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_m_valid got %b want 0", m_valid); end
        tests++; if (m_data !== 16'd0) begin fails++; $display("[TB] FAIL reset_m_data got %0d want 0", m_data); end
        tests++; if (m_last !== 1'b0) begin fails++; $display("[TB] FAIL reset_m_last got %b want 0", m_last); end
        tests++; if (s6_wr_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_s6_wr_ready got %b want 1", s6_wr_ready); end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m_ready = i[0];
            @(negedge clk);
            tests++;
            if (m_valid !== 1'b0 || m_data !== 16'd0 || m_last !== 1'b0) begin
                fails++;
                $display("[TB] FAIL idle_outputs got valid=%b data=%0d last=%b want 0/0/0", m_valid, m_data, m_last);
            end
        end
        m_ready = 0;
    endtask

    task automatic test_single_frame();
        elem_t exp;
        do_reset();
        m_ready = 1;
        for (int i = 0; i < N - 1; i++) write8(i, i + 1, 0);
        tests++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_precommit_valid got %b want 0", m_valid); end
        write8(N - 1, N, 1);
        for (int i = 0; i < N; i++) begin
            exp = elem_t'(i + 1);
            tests++; if (m_valid !== 1'b1) begin fails++; $display("[TB] FAIL single_valid[%0d] got %b want 1", i, m_valid); end
            tests++; if (m_data !== exp) begin fails++; $display("[TB] FAIL single_data[%0d] got %0d want %0d", i, $signed(m_data), exp); end
            tests++; if (m_last !== (i == N - 1)) begin fails++; $display("[TB] FAIL single_last[%0d] got %b want %b", i, m_last, (i == N - 1)); end
            @(negedge clk);
        end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_after_valid got %b want 0", m_valid); end
        m_ready = 0;
    endtask

    task automatic test_back_to_back();
        elem_t exp;
        bit    exp_last;
        do_reset();
        m_ready = 0;
        for (int i = 0; i < N; i++) write8(i, -(i + 1), i == N - 1);
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("[TB] FAIL pp_ready_after_a got %b want 1", wr_ready); end
        for (int i = 0; i < N; i++) write8(i, 100 + i, i == N - 1);
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("[TB] FAIL pp_ready_after_b got %b want 0", wr_ready); end
        for (int i = 0; i < 3; i++) write8(i, 16'h7777, 1);
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("[TB] FAIL pp_ready_blocked got %b want 0", wr_ready); end
        m_ready = 1;
        for (int k = 0; k < 2 * N; k++) begin
            exp = (k < N) ? elem_t'(-(k + 1)) : elem_t'(100 + k - N);
            exp_last = (k == N - 1) || (k == 2 * N - 1);
            tests++; if (m_valid !== 1'b1) begin fails++; $display("[TB] FAIL pp_valid[%0d] got %b want 1", k, m_valid); end
            tests++; if (m_data !== exp) begin fails++; $display("[TB] FAIL pp_data[%0d] got %0d want %0d", k, $signed(m_data), exp); end
            tests++; if (m_last !== exp_last) begin fails++; $display("[TB] FAIL pp_last[%0d] got %b want %b", k, m_last, exp_last); end
            tests++; if (wr_ready !== (k >= N)) begin fails++; $display("[TB] FAIL pp_wr_ready[%0d] got %b want %b", k, wr_ready, (k >= N)); end
            @(negedge clk);
        end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL pp_after_valid got %b want 0", m_valid); end
        m_ready = 0;
    endtask

    // Reference model: a FIFO of committed elements plus a count of outstanding frames (capacity 2).
    task automatic test_random_backpressure();
        elem_t exp_q[$];
        elem_t wbuf[N];
        int    pending, rd_idx, wa, commits, done, cyc;
        bit    acc, hs, prev_stall;
        logic [15:0] prev_data;
        logic  prev_last;
        do_reset();
        pending = 0; rd_idx = 0; wa = 0; commits = 0; done = 0; cyc = 0;
        prev_stall = 0; prev_data = '0; prev_last = 0;
        while (done < RAND_FRAMES && cyc < CYCLE_CAP) begin
            tests++; if (wr_ready !== (pending < 2)) begin fails++; $display("[TB] FAIL rand_wr_ready cyc %0d got %b want %b", cyc, wr_ready, (pending < 2)); end
            tests++; if (m_valid !== (pending > 0)) begin fails++; $display("[TB] FAIL rand_m_valid cyc %0d got %b want %b", cyc, m_valid, (pending > 0)); end
            if (pending > 0) begin
                tests++; if (m_data !== exp_q[0]) begin fails++; $display("[TB] FAIL rand_m_data cyc %0d got %0d want %0d", cyc, $signed(m_data), exp_q[0]); end
                tests++; if (m_last !== (rd_idx == N - 1)) begin fails++; $display("[TB] FAIL rand_m_last cyc %0d got %b want %b", cyc, m_last, (rd_idx == N - 1)); end
            end
            if (prev_stall) begin
                tests++;
                if (m_data !== prev_data || m_last !== prev_last) begin
                    fails++;
                    $display("[TB] FAIL rand_stall cyc %0d got %0d/%b want %0d/%b", cyc, m_data, m_last, prev_data, prev_last);
                end
            end
            wr_en   = (commits < RAND_FRAMES) && ($urandom_range(0, 99) < 70);
            wr_addr = 3'(wa);
            wr_data = 16'($urandom);
            wr_last = (wa == N - 1);
            m_ready = ($urandom_range(0, 99) < 60);
            acc = wr_en && (pending < 2);
            hs  = (pending > 0) && m_ready;
            prev_stall = (pending > 0) && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (hs) begin
                void'(exp_q.pop_front());
                rd_idx++;
                if (rd_idx == N) begin rd_idx = 0; pending--; done++; end
            end
            if (acc) begin
                wbuf[wa] = elem_t'(wr_data);
                if (wa == N - 1) begin
                    for (int i = 0; i < N; i++) exp_q.push_back(wbuf[i]);
                    pending++; commits++; wa = 0;
                end else begin
                    wa++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        tests++; if (done != RAND_FRAMES) begin fails++; $display("[TB] FAIL rand_timeout got %0d frames want %0d", done, RAND_FRAMES); end
        idle_inputs();
    endtask

    task automatic test_boundary_writes();
        elem_t exp;
        do_reset();
        s6_m_ready = 1;
        for (int i = 0; i < N6; i++) write6(i, 200 + i, 0);
        tests++; if (s6_m_valid !== 1'b0) begin fails++; $display("[TB] FAIL n6_precommit_valid got %b want 0", s6_m_valid); end
        write6(N6, 999, 1);
        for (int i = 0; i < N6; i++) begin
            exp = elem_t'(200 + i);
            tests++; if (s6_m_valid !== 1'b1) begin fails++; $display("[TB] FAIL n6_valid[%0d] got %b want 1", i, s6_m_valid); end
            tests++; if (s6_m_data !== exp) begin fails++; $display("[TB] FAIL n6_data[%0d] got %0d want %0d", i, $signed(s6_m_data), exp); end
            tests++; if (s6_m_last !== (i == N6 - 1)) begin fails++; $display("[TB] FAIL n6_last[%0d] got %b want %b", i, s6_m_last, (i == N6 - 1)); end
            @(negedge clk);
        end
        tests++; if (s6_m_valid !== 1'b0) begin fails++; $display("[TB] FAIL n6_after_valid got %b want 0", s6_m_valid); end
        s6_m_ready = 0;
    endtask

    task automatic test_reset_mid_frame();
        elem_t exp;
        do_reset();
        for (int i = 0; i < N; i++) write8(i, 10 + i, i == N - 1);
        m_ready = 1;
        for (int k = 0; k < 3; k++) begin
            exp = elem_t'(10 + k);
            tests++; if (m_data !== exp) begin fails++; $display("[TB] FAIL mid_pre_data[%0d] got %0d want %0d", k, $signed(m_data), exp); end
            @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tests++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_valid got %b want 0", m_valid); end
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("[TB] FAIL mid_reset_wr_ready got %b want 1", wr_ready); end
        @(negedge clk);
        tests++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_no_partial got %b want 0", m_valid); end
        for (int i = 0; i < N; i++) write8(i, 50 + i, i == N - 1);
        for (int k = 0; k < N; k++) begin
            exp = elem_t'(50 + k);
            tests++; if (m_data !== exp || m_valid !== 1'b1) begin fails++; $display("[TB] FAIL mid_new_data[%0d] got %0d valid %b want %0d valid 1", k, $signed(m_data), m_valid, exp); end
            tests++; if (m_last !== (k == N - 1)) begin fails++; $display("[TB] FAIL mid_new_last[%0d] got %b want %b", k, m_last, (k == N - 1)); end
            @(negedge clk);
        end
        m_ready = 0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_boundary_writes();
        test_reset_mid_frame();
        test_random_backpressure();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/layer_vector_streamer.md
# layer_vector_streamer

Double-buffered transmitter that produces the input stream consumed by a layer block (the `s_valid`/`s_ready`/`data_in` end of the layer). A control or host side writes one N-element vector of signed T-bit values per frame into a ping-pong buffer. The block replays each committed frame over a valid/ready master stream, one element per handshake, while the other bank is refilled. It sits between the vector loader and the first network layer.

## Interface
- `T`, 16: element width in bits (signed).
- `N`, 8: elements per frame; N ≥ 2.
- `AW`, `$clog2(N)`: element address width (derived, not overridden).

- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  write strobe; accepted only when `wr_ready`=1.
- `wr_addr`  in  AW  element index within the current write bank.
- `wr_data`  in  T  element value.
- `wr_last`  in  1  with an accepted write: commit the write bank as a full frame.
- `wr_ready`  out  1  current write bank is not full.
- `m_valid`  out  1  element available on `m_data`.
- `m_ready`  in  1  downstream accepts the element.
- `m_data`  out  T  signed element; 0 when `m_valid`=0.
- `m_last`  out  1  `m_data` is element N-1 of the frame; 0 when `m_valid`=0.

## Operation
- State:
  - Two banks of N×T registers.
  - `full[1:0]` flags.
  - Write-bank pointer `wb`.
  - Read-bank pointer `rb`.
  - Read index `ri` (0..N-1).
- Reset (`reset`=0 at an edge):
  - `full`=0, `wb`=0, `rb`=0, `ri`=0.
  - Outputs after the edge: `wr_ready`=1, `m_valid`=0, `m_last`=0, `m_data`=0.
  - Bank contents are not cleared.
  - Reset mid-frame discards both banks; there is no partial transmission afterwards.
- Write side:
  - `wr_ready` = !`full[wb]`.
  - Accepted write (`wr_en` and `wr_ready`): `bank[wb][wr_addr]` ← `wr_data`.
  - Writes with `wr_addr` ≥ N are ignored, but `wr_last` on them still commits.
  - Elements never written since reset hold undefined contents; the writer owns completeness.
  - Accepted write with `wr_last`=1: `full[wb]` ← 1 and `wb` toggles, on the same edge.
  - `wr_en` while `wr_ready`=0 has no effect.
- Read side:
  - `m_valid` = `full[rb]`.
  - `m_data` = `bank[rb][ri]` (combinational mux from registers).
  - `m_last` = `m_valid` and (`ri`==N-1).
  - Handshake (`m_valid` and `m_ready`): `ri` increments.
  - If `ri`==N-1 at the handshake: `ri` ← 0, `full[rb]` ← 0, `rb` toggles.
- Simultaneous events:
  - A commit on one bank and a final handshake on the other in the same cycle both take effect.
  - Write and read never target the same bank in the same cycle, because write requires !full and read requires full.
- Frames are emitted in commit order.
- No element is dropped or duplicated.
- `m_ready` has no effect when `m_valid`=0.

## Timing
- Commit-to-stream latency:
  - Commit on edge k with the read side idle: `m_valid`=1 in the cycle after edge k.
  - First element handshake possible at edge k+1.
- Throughput: one element per cycle with `m_ready` held high.
  - Back-to-back frames with no bubble when the other bank is already full at the final handshake.
- Stall: with `m_valid`=1 and `m_ready`=0, `m_data`/`m_last` hold stable until the handshake (valid/ready stream rules).
- Both banks full: `wr_ready`=0 until the final handshake of the older frame.
  - `wr_ready` returns to 1 in the cycle after that edge.
- Outputs depend only on registered state. There is no combinational path from `m_ready` or `wr_en` to any output.

## Structure
- Package `layer_stream_pkg`:
  - Default `T`, `N` constants.
  - Typedef `elem_t` (logic signed [T-1:0]).
  - Typedef for the bank select.
- Sub-module `stream_bank`: one N×T register file with a write port and an asynchronous read port. Instantiated twice.
- Top level holds the pointers, `full` flags, `ri` counter and output muxing.

## Test plan
- Reset and idle: after `reset`=0 for 1 cycle, check `wr_ready`=1, `m_valid`=0, `m_data`=0, `m_last`=0. Toggling `m_ready` produces nothing.
- Single frame, N=8: write values 1..8 to addresses 0..7, `wr_last` on address 7, `m_ready`=1 → stream 1,2,…,8 on consecutive cycles, `m_last` only on 8, `m_valid` first high in the cycle after the commit edge.
- Ping-pong back-to-back: commit frame A (−1..−8) and then frame B (100..107) with `m_ready`=0. `wr_ready`=0 after B. Raise `m_ready` → 16 consecutive handshakes, A then B, no gap. `wr_ready` returns to 1 in the cycle after the 8th handshake.
- Random backpressure: 1000 random frames with random `wr_en`/`m_ready` (same style as the layer bench) → scoreboard matches every element and `m_last` position. `m_data` stable across every stall.
- Boundary writes: write with `wr_addr`=N when N is not a power of two (N=6) → ignored. Writes while `wr_ready`=0 → ignored, confirmed by unchanged stream content.
- Reset mid-frame: assert reset after 3 of 8 handshakes → `m_valid`=0 next cycle. A new committed frame then streams from element 0.
